// File: rtl/sensor_frame_collector.sv
// Collects (id, reading) samples into a shadow buffer and publishes a coherent frame on commit.
// Optional HOLD_LAST_EN: enables follow "ever sampled and not stale" instead of "sampled this frame".
module sensor_frame_collector #(
  parameter int TEMP_WIDTH = 8,
  parameter int S_NR       = 8,
  parameter int ID_WIDTH   = 3,
  parameter int TIMEOUT    = 1000
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       sample_valid_i,
  output logic                       sample_ready_o,
  input  logic [ID_WIDTH-1:0]        sample_id_i,
  input  logic [TEMP_WIDTH-1:0]      sample_data_i,
  input  logic                       frame_commit_i,
  output logic [S_NR*TEMP_WIDTH-1:0] sensors_data_o,
  output logic [S_NR-1:0]            sensors_en_o,
  output logic                       frame_valid_o,
  output logic [S_NR-1:0]            stale_o,
  output logic                       err_id_o
);

  localparam int AGE_W = $clog2(TIMEOUT + 1);
  localparam logic [AGE_W-1:0]  AGE_MAX = AGE_W'(TIMEOUT);
  localparam logic [ID_WIDTH:0] SNR_L   = (ID_WIDTH + 1)'(S_NR);

  typedef enum logic [1:0] {IDLE, COLLECT, PUBLISH} state_e;

  state_e                      state_q, state_d;
  logic [S_NR*TEMP_WIDTH-1:0]  shadow_q, shadow_d;
  logic [S_NR-1:0]             fresh_q, fresh_d;
  logic [AGE_W-1:0]            age_q [S_NR];
  logic [AGE_W-1:0]            age_d [S_NR];
  logic [S_NR*TEMP_WIDTH-1:0]  data_q, data_d;
  logic [S_NR-1:0]             en_q, en_d;
  logic                        fv_q, fv_d;
  logic                        err_q, err_d;
  logic [S_NR-1:0]             stale;
  logic                        accept, valid_id, publish;
`ifdef HOLD_LAST_EN
  logic [S_NR-1:0]             seen_q, seen_d;
`endif

  assign accept   = sample_valid_i & sample_ready_o;
  assign valid_id = ({1'b0, sample_id_i} < SNR_L);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (frame_commit_i)            state_d = PUBLISH;
        else if (accept && valid_id)   state_d = COLLECT;
      end
      COLLECT: if (frame_commit_i)     state_d = PUBLISH;
      PUBLISH:                         state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  always_comb begin
    sample_ready_o = (state_q != PUBLISH);
    publish        = (state_q == PUBLISH);
  end

  always_comb begin
    shadow_d = shadow_q;
    fresh_d  = publish ? '0 : fresh_q;
    data_d   = data_q;
    en_d     = en_q;
    fv_d     = publish;
    err_d    = err_q | (accept & ~valid_id);
`ifdef HOLD_LAST_EN
    seen_d   = seen_q;
`endif
    for (int i = 0; i < S_NR; i++) begin
      stale[i] = (age_q[i] == AGE_MAX);
      age_d[i] = stale[i] ? age_q[i] : age_q[i] + AGE_W'(1);
      if (accept && valid_id && sample_id_i == ID_WIDTH'(i)) begin
        shadow_d[i*TEMP_WIDTH +: TEMP_WIDTH] = sample_data_i;
        fresh_d[i] = 1'b1;
        age_d[i]   = '0;
`ifdef HOLD_LAST_EN
        seen_d[i]  = 1'b1;
`endif
      end
    end
    // Staleness is judged on the ages as they stand at the publish edge.
    if (publish) begin
      data_d = shadow_q;
`ifdef HOLD_LAST_EN
      en_d   = seen_q & ~stale;
`else
      en_d   = fresh_q & ~stale;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shadow_q <= '0;
      fresh_q  <= '0;
      data_q   <= '0;
      en_q     <= '0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
      for (int i = 0; i < S_NR; i++) age_q[i] <= AGE_MAX;
`ifdef HOLD_LAST_EN
      seen_q   <= '0;
`endif
    end else begin
      shadow_q <= shadow_d;
      fresh_q  <= fresh_d;
      data_q   <= data_d;
      en_q     <= en_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
      for (int i = 0; i < S_NR; i++) age_q[i] <= age_d[i];
`ifdef HOLD_LAST_EN
      seen_q   <= seen_d;
`endif
    end
  end

  assign sensors_data_o = data_q;
  assign sensors_en_o   = en_q;
  assign frame_valid_o  = fv_q;
  assign stale_o        = stale;
  assign err_id_o       = err_q;

endmodule

// File: tb/tb_sensor_frame_collector.sv
// Randomized and directed bench for sensor_frame_collector with a frame-level reference model.
module tb_sensor_frame_collector;

  localparam int TW   = 8;
  localparam int S_NR = 6;
  localparam int IDW  = 3;
  localparam int T    = 16;

  logic              clk_i = 1'b0;
  logic              rst_n_i = 1'b0;
  logic              sample_valid_i = 1'b0;
  logic              sample_ready_o;
  logic [IDW-1:0]    sample_id_i = '0;
  logic [TW-1:0]     sample_data_i = '0;
  logic              frame_commit_i = 1'b0;
  logic [S_NR*TW-1:0] sensors_data_o;
  logic [S_NR-1:0]   sensors_en_o;
  logic              frame_valid_o;
  logic [S_NR-1:0]   stale_o;
  logic              err_id_o;

  sensor_frame_collector #(.TEMP_WIDTH(TW), .S_NR(S_NR), .ID_WIDTH(IDW), .TIMEOUT(T)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .sample_valid_i(sample_valid_i), .sample_ready_o(sample_ready_o),
    .sample_id_i(sample_id_i), .sample_data_i(sample_data_i),
    .frame_commit_i(frame_commit_i),
    .sensors_data_o(sensors_data_o), .sensors_en_o(sensors_en_o),
    .frame_valid_o(frame_valid_o), .stale_o(stale_o), .err_id_o(err_id_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame-level view, staleness from edge timestamps.
  logic [TW-1:0]      m_shadow [S_NR];
  bit                 m_fresh  [S_NR];
  bit                 m_seen   [S_NR];
  longint             m_last   [S_NR];
  longint             m_e;
  bit                 m_pub, m_err, m_fv;
  logic [S_NR*TW-1:0] m_data;
  logic [S_NR-1:0]    m_en;

  function automatic bit m_stale(int i, longint e);
    return (e - m_last[i]) >= T;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < S_NR; i++) begin
      m_shadow[i] = '0; m_fresh[i] = 0; m_seen[i] = 0; m_last[i] = -T;
    end
    m_e = 0; m_pub = 0; m_err = 0; m_fv = 0; m_data = '0; m_en = '0;
  endtask

  task automatic m_step();
    longint e_old;
    int     sid;
    e_old = m_e;
    m_e++;
    if (m_pub) begin
      for (int i = 0; i < S_NR; i++) begin
        m_data[i*TW +: TW] = m_shadow[i];
`ifdef HOLD_LAST_EN
        m_en[i] = m_seen[i] && !m_stale(i, e_old);
`else
        m_en[i] = m_fresh[i] && !m_stale(i, e_old);
`endif
        m_fresh[i] = 0;
      end
      m_fv = 1; m_pub = 0;
    end else begin
      m_fv = 0;
      if (sample_valid_i) begin
        sid = int'(sample_id_i);
        if (sid < S_NR) begin
          m_shadow[sid] = sample_data_i; m_fresh[sid] = 1; m_seen[sid] = 1; m_last[sid] = m_e;
        end else m_err = 1;
      end
      if (frame_commit_i) m_pub = 1;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk_i or negedge rst_n_i);
      if (!rst_n_i) m_reset();
      else m_step();
    end
  end

  always @(negedge clk_i) begin
    logic [S_NR-1:0] s;
    if (rst_n_i) begin
      for (int i = 0; i < S_NR; i++) s[i] = m_stale(i, m_e);
      chk("ready", 64'(sample_ready_o), 64'(!m_pub));
      chk("data", 64'(sensors_data_o), 64'(m_data));
      chk("en", 64'(sensors_en_o), 64'(m_en));
      chk("frame_valid", 64'(frame_valid_o), 64'(m_fv));
      chk("stale", 64'(stale_o), 64'(s));
      chk("err_id", 64'(err_id_o), 64'(m_err));
    end
  end

  task automatic send(input int id, input int d, input bit commit);
    int n = 0;
    @(negedge clk_i);
    sample_valid_i = 1'b1; sample_id_i = IDW'(id); sample_data_i = TW'(d); frame_commit_i = commit;
    while (!sample_ready_o && n < 10) begin @(negedge clk_i); n++; end
    if (n >= 10) chk("send_timeout", 64'(n), 64'(0));
    @(posedge clk_i); #1;
    sample_valid_i = 1'b0; frame_commit_i = 1'b0;
  endtask

  task automatic do_commit();
    @(negedge clk_i);
    frame_commit_i = 1'b1;
    @(posedge clk_i); #1;
    frame_commit_i = 1'b0;
  endtask

  task automatic next_edge();
    @(posedge clk_i); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_data", 64'(sensors_data_o), 64'(0));
    chk("rst_en", 64'(sensors_en_o), 64'(0));
    chk("rst_fv", 64'(frame_valid_o), 64'(0));
    chk("rst_err", 64'(err_id_o), 64'(0));
    chk("rst_stale", 64'(stale_o), 64'h3F);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("ready_after_rst", 64'(sample_ready_o), 64'(1));

    // Basic frame
    send(2, 'h19, 0);
    send(5, 'h2A, 0);
    do_commit();
    chk("ready_in_publish", 64'(sample_ready_o), 64'(0));
    next_edge();
    chk("t2_fv", 64'(frame_valid_o), 64'(1));
    chk("t2_b2", 64'(sensors_data_o[2*TW +: TW]), 64'h19);
    chk("t2_b5", 64'(sensors_data_o[5*TW +: TW]), 64'h2A);
    chk("t2_en", 64'(sensors_en_o), 64'b100100);
    chk("t2_stale25", 64'({stale_o[5], stale_o[2]}), 64'(0));
    next_edge();
    chk("t2_fv_drop", 64'(frame_valid_o), 64'(0));

    // Empty frame
    do_commit();
    next_edge();
    chk("t3_fv", 64'(frame_valid_o), 64'(1));
`ifdef HOLD_LAST_EN
    chk("t3_en", 64'(sensors_en_o), 64'b100100);
`else
    chk("t3_en", 64'(sensors_en_o), 64'(0));
`endif
    chk("t3_b2", 64'(sensors_data_o[2*TW +: TW]), 64'h19);

    // Overwrite and same-edge sample+commit
    send(3, 'h10, 0);
    send(3, 'h12, 0);
    send(4, 'h33, 1);
    next_edge();
    chk("t4_b3", 64'(sensors_data_o[3*TW +: TW]), 64'h12);
    chk("t4_b4", 64'(sensors_data_o[4*TW +: TW]), 64'h33);
`ifndef HOLD_LAST_EN
    chk("t4_en", 64'(sensors_en_o), 64'b011000);
`endif

    // Timeout
    send(1, 'h44, 0);
    repeat (T) @(posedge clk_i);
    #1;
    chk("t5_stale1", 64'(stale_o[1]), 64'(1));
    do_commit();
    next_edge();
    chk("t5_en1", 64'(sensors_en_o[1]), 64'(0));
    send(1, 'h45, 0);
    do_commit();
    next_edge();
    chk("t5_en1_fresh", 64'(sensors_en_o[1]), 64'(1));
    do_commit();
    next_edge();
`ifdef HOLD_LAST_EN
    chk("t5_en1_hold", 64'(sensors_en_o[1]), 64'(1));
`else
    chk("t5_en1_nohold", 64'(sensors_en_o[1]), 64'(0));
`endif

    // Out-of-range ids
    send(6, 'h77, 0);
    @(negedge clk_i);
    chk("t6_err", 64'(err_id_o), 64'(1));
    send(7, 'h78, 0);
    do_commit();
    next_edge();
    chk("t6_err_sticky", 64'(err_id_o), 64'(1));
    chk("t6_shadow", 64'(sensors_data_o), 64'h2A3312194500);

    // Reset during PUBLISH
    do_commit();
    rst_n_i = 1'b0;
    #1;
    chk("t6_rst_fv", 64'(frame_valid_o), 64'(0));
    chk("t6_rst_err", 64'(err_id_o), 64'(0));
    chk("t6_rst_data", 64'(sensors_data_o), 64'(0));
    chk("t6_rst_stale", 64'(stale_o), 64'h3F);
    next_edge();
    chk("t6_rst_fv2", 64'(frame_valid_o), 64'(0));
    rst_n_i = 1'b1;
    next_edge();
    chk("t6_rel_fv", 64'(frame_valid_o), 64'(0));

    // Random traffic
    repeat (800) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6)      send($urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 7) == 0);
      else if (r < 8) do_commit();
      else            repeat ($urandom_range(1, 20)) @(posedge clk_i);
    end
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
